// File: rtl/calc_drv_pkg.sv
// Shared constants and port FSM encoding for the calc request sequencer.
package calc_drv_pkg;

  localparam int CMD_NOP = 0;
  localparam int CMD_ADD = 1;
  localparam int CMD_SUB = 2;
  localparam int CMD_LSH = 5;
  localparam int CMD_RSH = 6;

  localparam int RESP_NONE = 0;
  localparam int RESP_OK   = 1;
  localparam int RESP_ERR  = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_OP1  = 3'd1,
    ST_OP2  = 3'd2,
    ST_WAIT = 3'd3,
    ST_RSP  = 3'd4
  } port_state_e;

endpackage

// File: rtl/calc_drv_port.sv
// One calc DUT port: transaction FIFO, two-cycle request driver, response wait
// with timeout, and a held response awaiting the output arbiter.
module calc_drv_port
  import calc_drv_pkg::*;
#(
  parameter int DW      = 32,
  parameter int CW      = 4,
  parameter int RW      = 2,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic          c_clk,
  input  logic          reset,
  input  logic          push,
  input  logic [CW-1:0] push_cmd,
  input  logic [DW-1:0] push_op1,
  input  logic [DW-1:0] push_op2,
  input  logic [RW-1:0] out_resp,
  input  logic [DW-1:0] out_data,
  input  logic          grant,
  output logic          full,
  output logic [CW-1:0] req_cmd,
  output logic [DW-1:0] req_data,
  output logic          rsp_pend,
  output logic [RW-1:0] rsp_code,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_to,
  output logic          in_wait,
  output logic          busy_next,
  output logic [2:0]    state
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CNW = $clog2(DEPTH + 1);
  // The wait counter only ever holds 0..TIMEOUT-1.
  localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  port_state_e   state_q, state_d;
  logic [CW-1:0] cmd_mem_q [DEPTH];
  logic [CW-1:0] cmd_mem_d [DEPTH];
  logic [DW-1:0] op1_mem_q [DEPTH];
  logic [DW-1:0] op1_mem_d [DEPTH];
  logic [DW-1:0] op2_mem_q [DEPTH];
  logic [DW-1:0] op2_mem_d [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNW-1:0] count_q, count_d;
  logic [TW-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]  cur_op2_q, cur_op2_d;
  logic [CW-1:0]  req_cmd_q, req_cmd_d;
  logic [DW-1:0]  req_data_q, req_data_d;
  logic [RW-1:0]  code_q, code_d;
  logic [DW-1:0]  data_q, data_d;
  logic           to_q, to_d;
  logic           pop;

  assign full = (count_q == CNW'(DEPTH));
  assign pop  = (state_q == ST_IDLE) && (count_q != '0);

  always_comb begin
    state_d    = state_q;
    cmd_mem_d  = cmd_mem_q;
    op1_mem_d  = op1_mem_q;
    op2_mem_d  = op2_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    cnt_d      = cnt_q;
    cur_op2_d  = cur_op2_q;
    code_d     = code_q;
    data_d     = data_q;
    to_d       = to_q;
    req_cmd_d  = CW'(CMD_NOP);
    req_data_d = '0;

    if (push) begin
      cmd_mem_d[wr_ptr_q] = push_cmd;
      op1_mem_d[wr_ptr_q] = push_op1;
      op2_mem_d[wr_ptr_q] = push_op2;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Request outputs are registered, so they are computed for the next state.
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          state_d    = ST_OP1;
          req_cmd_d  = cmd_mem_q[rd_ptr_q];
          req_data_d = op1_mem_q[rd_ptr_q];
          cur_op2_d  = op2_mem_q[rd_ptr_q];
        end
      end
      ST_OP1: begin
        state_d    = ST_OP2;
        req_data_d = cur_op2_q;
      end
      ST_OP2: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        if (out_resp != RW'(RESP_NONE)) begin
          state_d = ST_RSP;
          code_d  = out_resp;
          data_d  = out_data;
          to_d    = 1'b0;
        end else if (cnt_q == TW'(TIMEOUT - 1)) begin
          state_d = ST_RSP;
          code_d  = '0;
          data_d  = '0;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RSP: begin
        if (grant) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_next = (count_d != '0) || (state_d != ST_IDLE);
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        cmd_mem_q[i] <= '0;
        op1_mem_q[i] <= '0;
        op2_mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cnt_q      <= '0;
      cur_op2_q  <= '0;
      req_cmd_q  <= '0;
      req_data_q <= '0;
      code_q     <= '0;
      data_q     <= '0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_mem_q  <= cmd_mem_d;
      op1_mem_q  <= op1_mem_d;
      op2_mem_q  <= op2_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cnt_q      <= cnt_d;
      cur_op2_q  <= cur_op2_d;
      req_cmd_q  <= req_cmd_d;
      req_data_q <= req_data_d;
      code_q     <= code_d;
      data_q     <= data_d;
      to_q       <= to_d;
    end
  end

  assign req_cmd  = req_cmd_q;
  assign req_data = req_data_q;
  assign rsp_pend = (state_q == ST_RSP);
  assign rsp_code = code_q;
  assign rsp_data = data_q;
  assign rsp_to   = to_q;
  assign in_wait  = (state_q == ST_WAIT);
  assign state    = state_q;

endmodule

// File: rtl/calc_req_sequencer.sv
// Accepts calc transactions, fans them out to per-port drivers and returns
// their responses on one round-robin arbitrated bus.
module calc_req_sequencer
  import calc_drv_pkg::*;
#(
  parameter int NPORTS  = 4,
  parameter int DW      = 32,
  parameter int CW      = 4,
  parameter int RW      = 2,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                      c_clk,
  input  logic                      reset,
  // txn handshake: a transaction transfers on a rising edge where txn_valid
  // and txn_ready are both high; txn_ready depends only on the fill of the
  // FIFO selected by txn_port, never on txn_valid.
  input  logic                      txn_valid,
  output logic                      txn_ready,
  input  logic [$clog2(NPORTS)-1:0] txn_port,
  input  logic [CW-1:0]             txn_cmd,
  input  logic [DW-1:0]             txn_op1,
  input  logic [DW-1:0]             txn_op2,
  output logic [NPORTS*CW-1:0]      req_cmd_out,
  output logic [NPORTS*DW-1:0]      req_data_out,
  input  logic [NPORTS*RW-1:0]      out_resp,
  input  logic [NPORTS*DW-1:0]      out_data,
  output logic                      rsp_valid,
  output logic [$clog2(NPORTS)-1:0] rsp_port,
  output logic [RW-1:0]             rsp_code,
  output logic [DW-1:0]             rsp_data,
  output logic                      rsp_timeout,
  output logic                      busy,
  output logic                      proto_err,
  output logic [NPORTS*3-1:0]       dbg_state
);

  localparam int PW = $clog2(NPORTS);

  logic [NPORTS-1:0] full, push, rsp_pend, grant, p_to, p_wait, busy_next;
  logic [RW-1:0]     p_code [NPORTS];
  logic [DW-1:0]     p_data [NPORTS];

  logic [PW-1:0] last_q, last_d, arb_idx, sel;
  logic          found;
  logic          rsp_valid_q, rsp_valid_d, rsp_to_q, rsp_to_d;
  logic [PW-1:0] rsp_port_q, rsp_port_d;
  logic [RW-1:0] rsp_code_q, rsp_code_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          busy_q, busy_d, proto_err_q, proto_err_d;

  assign txn_ready = ~full[txn_port];

  always_comb begin
    push           = '0;
    push[txn_port] = txn_valid & ~full[txn_port];
  end

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    calc_drv_port #(
      .DW(DW), .CW(CW), .RW(RW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) u_port (
      .c_clk     (c_clk),
      .reset     (reset),
      .push      (push[p]),
      .push_cmd  (txn_cmd),
      .push_op1  (txn_op1),
      .push_op2  (txn_op2),
      .out_resp  (out_resp[p*RW +: RW]),
      .out_data  (out_data[p*DW +: DW]),
      .grant     (grant[p]),
      .full      (full[p]),
      .req_cmd   (req_cmd_out[p*CW +: CW]),
      .req_data  (req_data_out[p*DW +: DW]),
      .rsp_pend  (rsp_pend[p]),
      .rsp_code  (p_code[p]),
      .rsp_data  (p_data[p]),
      .rsp_to    (p_to[p]),
      .in_wait   (p_wait[p]),
      .busy_next (busy_next[p]),
      .state     (dbg_state[p*3 +: 3])
    );
  end

  // Round-robin: search starts one past the last granted port.
  always_comb begin
    grant   = '0;
    found   = 1'b0;
    sel     = last_q;
    arb_idx = '0;
    for (int i = 1; i <= NPORTS; i++) begin
      arb_idx = PW'((int'(last_q) + i) % NPORTS);
      if (!found && rsp_pend[arb_idx]) begin
        found = 1'b1;
        sel   = arb_idx;
      end
    end
    if (found) grant[sel] = 1'b1;
    last_d      = sel;
    rsp_valid_d = found;
    rsp_port_d  = sel;
    rsp_code_d  = found ? p_code[sel] : '0;
    rsp_data_d  = found ? p_data[sel] : '0;
    rsp_to_d    = found & p_to[sel];

    proto_err_d = proto_err_q;
    for (int p = 0; p < NPORTS; p++) begin
      if ((out_resp[p*RW +: RW] != RW'(RESP_NONE)) && !p_wait[p]) proto_err_d = 1'b1;
    end
    busy_d = |busy_next;
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      last_q      <= PW'(NPORTS - 1);
      rsp_valid_q <= 1'b0;
      rsp_port_q  <= '0;
      rsp_code_q  <= '0;
      rsp_data_q  <= '0;
      rsp_to_q    <= 1'b0;
      busy_q      <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_port_q  <= rsp_port_d;
      rsp_code_q  <= rsp_code_d;
      rsp_data_q  <= rsp_data_d;
      rsp_to_q    <= rsp_to_d;
      busy_q      <= busy_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_port    = rsp_port_q;
  assign rsp_code    = rsp_code_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_to_q;
  assign busy        = busy_q;
  assign proto_err   = proto_err_q;

endmodule

// File: doc/calc_req_sequencer.md
# calc_req_sequencer

Synthesizable, parametrised request sequencer for the calc design family. It accepts whole calculator transactions (command, operand 1, operand 2, target port) on a single valid/ready input. It buffers them per port and drives the two-cycle calc request protocol on up to NPORTS DUT ports concurrently. It tracks each port's single outstanding command to completion or timeout and returns responses on one arbitrated output bus. It sits between the stimulus/test generator and the calc DUT, replacing hand-timed per-port drive.

## Interface
- NPORTS, 4, number of DUT request ports
- DW, 32, operand/result width
- CW, 4, command width
- RW, 2, response code width
- DEPTH, 4, per-port transaction FIFO depth (power of 2, ≥2)
- TIMEOUT, 255, max WAIT cycles before abandoning a command (≥1)

- c_clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- txn_valid  in  1  transaction offered
- txn_ready  out  1  selected port FIFO not full
- txn_port  in  $clog2(NPORTS)  target port, 0-based
- txn_cmd  in  CW  command code, passed through unchecked
- txn_op1 / txn_op2  in  DW  operands
- req_cmd_out  out  NPORTS*CW  per-port command to DUT, port p at [p*CW +: CW]
- req_data_out  out  NPORTS*DW  per-port data to DUT
- out_resp  in  NPORTS*RW  per-port DUT response code
- out_data  in  NPORTS*DW  per-port DUT result
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_port / rsp_code / rsp_data  out  $clog2(NPORTS) / RW / DW  response contents
- rsp_timeout  out  1  qualifies rsp_valid: command abandoned, rsp_code=0, rsp_data=0
- busy  out  1  any FIFO non-empty or any port not IDLE
- proto_err  out  1  sticky: nonzero out_resp seen on a port not in WAIT

## Operation
- Accept when txn_valid & txn_ready. txn_ready is combinational on txn_port and reflects FIFO count only. A push to a full FIFO is blocked even when a pop happens in the same cycle.
- Per-port FSM:
  - IDLE: if FIFO non-empty, pop and go to OP1.
  - OP1: drive cmd/op1, then go to OP2.
  - OP2: drive CMD_NOP/op2, then go to WAIT.
  - WAIT: drive NOP/0 and count. Nonzero out_resp captures code and data, then go to RSP. Count reaching TIMEOUT goes to RSP with the timeout flag set.
  - RSP: hold until granted by the arbiter, then go to IDLE.
- Responses use round-robin arbitration across ports in RSP. Search starts at the port after the last grant. One grant per cycle.
- In every state other than OP1/OP2, req_cmd_out=CMD_NOP and req_data_out=0.
- Only one command is outstanding per port. Ports operate independently and in parallel.

## Timing
- Reset (asynchronous): all FIFOs empty, all FSMs IDLE, counters 0, req_cmd_out/req_data_out 0, rsp_* 0, busy 0, proto_err 0. Commands in flight are dropped.
- All outputs except txn_ready are registered.
- Transaction accepted at edge E0 into an empty FIFO of an idle port:
  - cmd/op1 are visible E1→E2.
  - NOP/op2 are visible E2→E3.
  - WAIT starts at E3.
- A response sampled at edge Er with no contention gives rsp_valid high Er+1→Er+2.
- Timeout: the TIMEOUT-th WAIT cycle with out_resp=0 enters RSP.
- Back-to-back queued transactions on one port: the next OP1 follows the grant cycle via one IDLE cycle.
- out_resp is sampled only in WAIT. Nonzero values elsewhere set proto_err and are otherwise ignored.

## Structure
- Package calc_drv_pkg holds:
  - CMD_NOP=0, CMD_ADD=1, CMD_SUB=2, CMD_LSH=5, CMD_RSH=6
  - RESP_NONE=0, RESP_OK=1, RESP_ERR=2
  - the port FSM state enum
- Sub-module calc_drv_port contains one FIFO, the FSM, the timeout counter and the captured-response register. It is generated NPORTS times.
- The top level holds the port demux, the round-robin arbiter, busy and proto_err.

## Test plan
- ADD 0xFFFF0000 / 0x0000FFFF to port 0:
  - req_cmd_out[0]=1 with data 0xFFFF0000 for one cycle, then 0 with 0x0000FFFF.
  - Model returns resp 1, data 0xFFFFFFFF.
  - Expect a single rsp_valid with port 0, code 1, data 0xFFFFFFFF, timeout 0.
- DEPTH=4, model silent on port 2, push 6 transactions back-to-back:
  - 1 goes in flight and 4 are queued.
  - The 6th sees txn_ready=0.
  - Other ports keep txn_ready=1.
- All 4 ports respond at the same edge: expect 4 rsp_valid pulses on consecutive cycles, ports in round-robin order, no loss, data intact.
- TIMEOUT=15, model never responds:
  - rsp_timeout=1, code 0 after 15 WAIT cycles.
  - The next queued transaction then issues normally.
- SUB 0x00000000 − 0x00000001, model returns resp 2: expect rsp_code=2 propagated.
- Reset mid-WAIT on all ports:
  - req outputs go to 0 immediately, busy=0, txn_ready=1.
  - A stray late out_resp then sets proto_err.
  - The next reset clears proto_err.
